// File: rtl/dec_pkg.sv
// Shared definitions for the 3-to-8 hold decoder: FSM state encoding,
// counter width and the binary-to-one-hot helper.
package dec_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   function automatic logic [7:0] decode3(input logic [2:0] code);
      logic [7:0] one;
      one = 8'b0000_0001;
      return one << code;
   endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a zero flag. Load wins over clear, clear wins
// over decrement; decrement saturates at zero.
module hold_counter
   import dec_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             clr,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder3to8_hold.sv
// 3-to-8 decoder that holds each accepted one-hot word for HOLD_CYCLES
// cycles behind a valid/ready handshake.
// Optional feature: define DEC3TO8_ABORT_EN to add the abort input, which
// drops an in-progress hold and blocks acceptance while high.
module decoder3to8_hold
   import dec_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out,
   output logic       out_valid,
   output logic       busy
`ifdef DEC3TO8_ABORT_EN
   ,
   input  logic       abort
`endif
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       out_q, out_d;
   logic             xfer;
   logic             abort_w;
   logic             cnt_load, cnt_clr, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt;

`ifdef DEC3TO8_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Ready in IDLE or on the final hold cycle, so back-to-back codes leave no gap.
   assign in_ready = !abort_w && ((state_q == IDLE) || cnt_zero);
   assign xfer     = in_valid && in_ready;

   hold_counter u_hold_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .clr      (cnt_clr),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Next-state, next-output and counter control.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      cnt_load = 1'b0;
      cnt_clr  = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d  = HOLD;
               out_d    = decode3(in);
               cnt_load = 1'b1;
            end
         end
         HOLD: begin
            if (abort_w) begin
               state_d = IDLE;
               out_d   = 8'b0;
               cnt_clr = 1'b1;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (xfer) begin
               out_d    = decode3(in);
               cnt_load = 1'b1;
            end else begin
               state_d = IDLE;
               out_d   = 8'b0;
            end
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= 8'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign out       = out_q;
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q == HOLD);

endmodule

// File: doc/decoder3to8_hold.md
DECODER3TO8_HOLD -- requirements
Module: decoder3to8_hold

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of clock cycles each decoded one-hot word stays asserted; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in  input  3  binary code to decode; bit 2 is the MSB.
REQ-005 in_valid  input  1  in carries a code for acceptance.
REQ-006 in_ready  output  1  block accepts a code this cycle; transfer occurs when in_valid && in_ready.
REQ-007 out  output  8  registered one-hot word; out[k]=1 iff the accepted code equals k; all zeros when idle.
REQ-008 out_valid  output  1  out holds a decoded word.
REQ-009 busy  output  1  high in HOLD state.
REQ-010 The design has one clock, clk; rst is synchronous and active-high.

Function
REQ-011 FSM has two states, IDLE and HOLD, plus an 8-bit down-counter cnt.
REQ-012 In IDLE: in_ready=1, out=8'b0, out_valid=0, busy=0.
REQ-013 Transfer in IDLE: next cycle out=8'b1<<in, out_valid=1, state=HOLD, cnt=HOLD_CYCLES-1; latency is 1 cycle.
REQ-014 In HOLD with cnt>0: in_ready=0, out and out_valid unchanged, cnt decrements by 1.
REQ-015 In HOLD with cnt==0 (final hold cycle): in_ready=1.
REQ-016 Final hold cycle with transfer: next cycle loads the new one-hot word and cnt=HOLD_CYCLES-1 and stays in HOLD; no gap, so out_valid stays high.
REQ-017 Final hold cycle without transfer: next cycle returns to IDLE with out=0 and out_valid=0.
REQ-018 Each accepted code is presented on out for exactly HOLD_CYCLES consecutive cycles.
REQ-019 HOLD_CYCLES=1: cnt is always 0 in HOLD, in_ready is permanently 1, and each code becomes a one-cycle pulse; back-to-back codes give consecutive pulses.
REQ-020 out is always one-hot when out_valid=1 and all zeros when out_valid=0.
REQ-021 in is ignored whenever no transfer occurs.

Reset
REQ-022 rst=1 at a clock edge forces IDLE, cnt=0, out=8'b0, out_valid=0, busy=0.
REQ-023 rst takes priority over every transfer and abort; a hold in progress is discarded.
REQ-024 in_ready=1 from the first cycle after reset is released.

Configuration
REQ-025 Macro DEC3TO8_ABORT_EN, when defined, adds port abort (input, 1 bit).
REQ-026 With DEC3TO8_ABORT_EN: abort=1 in HOLD forces IDLE next cycle (out=0, out_valid=0).
REQ-027 With DEC3TO8_ABORT_EN: in_ready=0 whenever abort=1, so abort beats acceptance in the same cycle.
REQ-028 With DEC3TO8_ABORT_EN: abort in IDLE has no effect other than blocking acceptance.
REQ-029 Without DEC3TO8_ABORT_EN: no abort port exists and every hold runs to completion.

Structure
REQ-030 Shared package dec_pkg holds the state encoding (IDLE=0, HOLD=1) and the constant CNT_W=8.
REQ-031 One sub-module, hold_counter, provides a loadable down-counter with a zero flag; decoding and the FSM stay in decoder3to8_hold.

Verification
REQ-032 Reset held 2 cycles, then released -> out=00000000, out_valid=0, in_ready=1, busy=0.
REQ-033 HOLD_CYCLES=4, in=3'd5 with a one-cycle valid -> out=00100000 for exactly 4 cycles, then 00000000; in_ready low for 3 of those cycles.
REQ-034 HOLD_CYCLES=4, code 7 followed by code 0 offered in the final hold cycle -> out=10000000 for 4 cycles, then 00000001 for 4 cycles with no gap.
REQ-035 HOLD_CYCLES=1, codes 0..7 offered on consecutive cycles -> out walks 00000001..10000000 one per cycle, in_ready always 1.
REQ-036 Mid-hold reset: code 2 accepted, rst asserted in the 2nd hold cycle -> out=0 on the next cycle and in_ready=1 after release.
REQ-037 DEC3TO8_ABORT_EN defined, code 6 accepted, abort together with in_valid (code 1) in the 2nd hold cycle -> next cycle out=0, code 1 not accepted.
